t04_seq_alu: RTL and testbench

T04_SEQ_ALU -- requirements
Module: t04_seq_alu

---
 rtl/t04_seq_alu.sv | 176 +++++++++++++++++
 tb/tb_t04_seq_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/t04_seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/branch ops plus bit-serial shifts
// (one bit per cycle), with registered result, branch flag and error flag.
module t04_seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             ctrl_err,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_BLTU = 4'd14,
        OP_BGEU = 4'd15
    } op_e;

    state_e           state_q, state_d;
    op_e              shop_q, shop_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             taken_q, taken_d;
    logic             err_q, err_d;

    op_e              op_in;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH-1:0] alu_res;
    logic             alu_taken;
    logic [WIDTH-1:0] shift_step;

    assign op_in    = op_e'(op);
    assign shamt    = b[SHW-1:0];
    assign is_shift = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);

    // Single-cycle datapath; shift ops with a zero amount pass a through.
    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        case (op_in)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res[0] = ($signed(a) < $signed(b));
            OP_SLTU: alu_res[0] = (a < b);
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_SLL, OP_SRL, OP_SRA: alu_res = a;
            OP_BEQ:  alu_taken = (a == b);
            OP_BNE:  alu_taken = (a != b);
            OP_BLT:  alu_taken = ($signed(a) < $signed(b));
            OP_BGE:  alu_taken = ($signed(a) >= $signed(b));
            OP_BLTU: alu_taken = (a < b);
            OP_BGEU: alu_taken = (a >= b);
            default: begin
                alu_res   = '0;
                alu_taken = 1'b0;
            end
        endcase
    end

    // SRA keeps the captured sign bit in the MSB, so replicating it is stable.
    always_comb begin
        case (shop_q)
            OP_SLL:  shift_step = {shreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, shreg_q[WIDTH-1:1]};
            OP_SRA:  shift_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            default: shift_step = shreg_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shop_d   = shop_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        taken_d  = taken_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ctrl_err) begin
                        result_d = '0;
                        taken_d  = 1'b0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (is_shift && (shamt != '0)) begin
                        shop_d  = op_in;
                        shreg_d = a;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        taken_d  = alu_taken;
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shift_step;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = shift_step;
                    taken_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            shop_q   <= OP_ADD;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            taken_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shop_q   <= shop_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            taken_q  <= taken_d;
            err_q    <= err_d;
        end
    end

    assign result       = result_q;
    assign branch_taken = taken_q;
    assign err          = err_q;
    assign done         = (state_q == DONE);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_t04_seq_alu.sv
// Scoreboard bench for t04_seq_alu: directed vectors queue expectations, a
// negedge monitor pops one per done pulse and checks value and completion cycle.
module tb_t04_seq_alu;

    logic        clk;
    logic        nRst;
    logic        start;
    logic [3:0]  op;
    logic        ctrl_err;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        branch_taken;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] res;
        logic        tk;
        logic        er;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          checks;
    int          errors;

    t04_seq_alu #(.WIDTH(32)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .start        (start),
        .op           (op),
        .ctrl_err     (ctrl_err),
        .a            (a),
        .b            (b),
        .result       (result),
        .branch_taken (branch_taken),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (nRst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_taken"}, {31'b0, branch_taken}, {31'b0, e.tk});
                chk({e.name, "_err"}, {31'b0, err}, {31'b0, e.er});
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic ce, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] er, input logic et,
                         input logic ee, input int unsigned lat, input string nm);
        exp_t e;
        @(negedge clk);
        op = o; ctrl_err = ce; a = av; b = bv; start = 1'b1;
        e.res = er; e.tk = et; e.er = ee; e.cyc = cyc + lat; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv ^ 32'h5; op = ~o; ctrl_err = ~ce;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 80; i++) begin
            if (!busy && sb.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (busy || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual busy=%0b pending=%0d required idle", nm, busy, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        nRst = 1'b1; start = 1'b0; op = 4'd0; ctrl_err = 1'b0; a = '0; b = '0;
        #1 nRst = 1'b0;
        #2;
        chk("rst_result", result, 32'h0);
        chk("rst_taken", {31'b0, branch_taken}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;

        issue(4'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1, "add_wrap");
        wait_idle("add_wrap");
        issue(4'd7, 1'b0, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, "sra31");
        wait_idle("sra31");
        issue(4'd2, 1'b0, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 1, "sll_sh0");
        issue(4'd12, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, "blt");
        issue(4'd14, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1, "bltu");
        issue(4'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1, "slt");
        issue(4'd4, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1, "sltu");
        issue(4'd5, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1, "xor");
        issue(4'd8, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1, "or");
        issue(4'd9, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1, "and");
        issue(4'd10, 1'b0, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1, "beq");
        issue(4'd11, 1'b0, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 1, "bne");
        issue(4'd13, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1, "bge");
        issue(4'd15, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, "bgeu");
        issue(4'd10, 1'b1, 32'h5, 32'h5, 32'h0, 1'b0, 1'b1, 1, "beq_cerr");
        issue(4'd2, 1'b1, 32'h1, 32'h5, 32'h0, 1'b0, 1'b1, 1, "sll_cerr");
        wait_idle("b2b");
        issue(4'd2, 1'b0, 32'h1, 32'h23, 32'h8, 1'b0, 1'b0, 4, "sll3");
        wait_idle("sll3");
        issue(4'd6, 1'b0, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1'b0, 5, "srl4");
        wait_idle("srl4");
        issue(4'd7, 1'b0, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0, 5, "sra4");
        wait_idle("sra4");
        issue(4'd7, 1'b0, 32'h4000_0000, 32'h1, 32'h2000_0000, 1'b0, 1'b0, 2, "sra1_pos");
        wait_idle("sra1_pos");

        // start held through an SRL with toggling operands, then a queued ADD
        begin
            exp_t e;
            int unsigned cap;
            @(negedge clk);
            op = 4'd6; ctrl_err = 1'b0; a = 32'h8000_00F0; b = 32'h5; start = 1'b1;
            cap = cyc + 1;
            e.res = 32'h0400_0007; e.tk = 1'b0; e.er = 1'b0; e.cyc = cap + 5; e.name = "srl5_hold";
            sb.push_back(e);
            repeat (5) begin
                @(negedge clk);
                chk("hold_busy", {31'b0, busy}, 32'h1);
                a = $urandom; b = $urandom;
            end
            @(negedge clk);
            op = 4'd0; a = 32'h3; b = 32'h4;
            e.res = 32'h7; e.tk = 1'b0; e.er = 1'b0; e.cyc = cap + 7; e.name = "add_after_hold";
            sb.push_back(e);
            @(negedge clk);
            chk("hold_idle_busy", {31'b0, busy}, 32'h0);
            @(negedge clk);
            start = 1'b0;
            wait_idle("hold");
        end

        issue(4'd0, 1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1, "add_cerr");
        issue(4'd1, 1'b0, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, "sub");
        wait_idle("sub");

        // async reset in the middle of a 10-bit SLL; nothing pushed, so any done is flagged
        @(negedge clk);
        op = 4'd2; ctrl_err = 1'b0; a = 32'h1; b = 32'hA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        #2 nRst = 1'b0;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_taken", {31'b0, branch_taken}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_err", {31'b0, err}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1 chk("inrst_busy", {31'b0, busy}, 32'h0);
        issue_after_reset();
        wait_idle("post_rst");
        repeat (15) @(negedge clk);
        chk("final_queue", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic issue_after_reset();
        exp_t e;
        @(negedge clk);
        nRst = 1'b1;
        op = 4'd0; ctrl_err = 1'b0; a = 32'd10; b = 32'd20; start = 1'b1;
        e.res = 32'd30; e.tk = 1'b0; e.er = 1'b0; e.cyc = cyc + 1; e.name = "add_post_rst";
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

endmodule
